// File: rtl/fix_rx_assembler.sv
// Purpose: assembles a received byte stream into one FIX frame and checks its begin string, size and CheckSum(10) field.
// Latency: rx_enable pulses exactly 1 cycle after the final SOH is accepted; frame_error pulses 1 cycle after the offending byte or idle cycle.
// Backpressure: byte_ready is low only during the single DONE/DROP cycle; a held byte waits there and is not lost.
module fix_rx_assembler #(
    parameter int FIX_PAYLOAD_LEN = 220,
    parameter int FIX_HEADER_LEN  = 42,
    parameter int TIMEOUT_CYCLES  = 1000000,
    localparam int MSG_LEN        = FIX_HEADER_LEN + FIX_PAYLOAD_LEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   rx_enable,
    output logic [MSG_LEN*8-1:0]   rx_fix_data,
    output logic                   frame_error,
    output logic [2:0]             error_code
);

    localparam int DW = MSG_LEN * 8;
    localparam int LW = $clog2(DW);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SOH = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BODY,
        S_CSUM,
        S_DONE,
        S_DROP
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   buf_q, buf_d;
    logic [DW-1:0]   out_q, out_d;
    logic [8:0]      cnt_q, cnt_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      snap_q, snap_d;    // running sum as of the most recent SOH
    logic [7:0]      exp_q, exp_d;      // checksum the trailer must carry
    logic [1:0]      tag_q, tag_d;      // how much of SOH,'1','0','=' has been matched
    logic [1:0]      dig_q, dig_d;      // checksum digits seen so far
    logic [9:0]      val_q, val_d;      // decimal value of the checksum digits
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [2:0]      code_q, code_d;
    logic            rdy_q;

    logic            accept;
    logic            overflow;
    logic            store;
    logic            is_digit;
    logic [3:0]      digit;
    logic [7:0]      hdr_exp;
    logic [LW-1:0]   wr_lsb;

    assign accept   = byte_valid && rdy_q;
    assign overflow = (cnt_q == 9'(MSG_LEN));
    assign is_digit = (byte_data >= 8'h30) && (byte_data <= 8'h39);
    assign digit    = byte_data[3:0];
    // Byte n lands n bytes below the top of the buffer; only used while cnt_q < MSG_LEN.
    assign wr_lsb   = LW'((MSG_LEN - 1 - int'(cnt_q)) * 8);
    // Expected character of "=FIX" for the byte about to be stored at index cnt_q.
    assign hdr_exp  = (cnt_q == 9'd1) ? 8'h3D :
                      (cnt_q == 9'd2) ? 8'h46 :
                      (cnt_q == 9'd3) ? 8'h49 : 8'h58;

    assign byte_ready  = rdy_q;
    assign rx_enable   = (state_q == S_DONE);
    assign frame_error = (state_q == S_DROP);
    assign rx_fix_data = out_q;
    assign error_code  = code_q;

    // Next-state logic: frame parsing, validation, timeout and buffer writes.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        snap_d  = snap_q;
        exp_d   = exp_q;
        tag_d   = tag_q;
        dig_d   = dig_q;
        val_d   = val_q;
        tmo_d   = tmo_q;
        code_d  = code_q;
        store   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept && byte_data == 8'h38) begin
                    store   = 1'b1;
                    state_d = S_START;
                end
            end
            S_START, S_BODY, S_CSUM: begin
                if (!accept) begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_DROP;
                        code_d  = 3'd5;
                    end
                end else if (overflow) begin
                    // The byte is consumed but never written: there is no room for it.
                    tmo_d   = '0;
                    state_d = S_DROP;
                    code_d  = 3'd1;
                end else begin
                    tmo_d = '0;
                    store = 1'b1;
                    if (state_q == S_START) begin
                        if (byte_data != hdr_exp) begin
                            state_d = S_DROP;
                            code_d  = 3'd2;
                        end else if (cnt_q == 9'd4) begin
                            state_d = S_BODY;
                        end
                    end else if (state_q == S_BODY) begin
                        if (byte_data == SOH) begin
                            snap_d = sum_q + byte_data;
                            tag_d  = 2'd1;
                        end else if (tag_q == 2'd1 && byte_data == 8'h31) begin
                            tag_d = 2'd2;
                        end else if (tag_q == 2'd2 && byte_data == 8'h30) begin
                            tag_d = 2'd3;
                        end else if (tag_q == 2'd3 && byte_data == 8'h3D) begin
                            tag_d   = 2'd0;
                            exp_d   = snap_q;
                            dig_d   = 2'd0;
                            val_d   = '0;
                            state_d = S_CSUM;
                        end else begin
                            tag_d = 2'd0;
                        end
                    end else begin
                        if (dig_q != 2'd3) begin
                            if (is_digit) begin
                                val_d = 10'(val_q * 10'd10) + {6'd0, digit};
                                dig_d = dig_q + 1'b1;
                            end else begin
                                state_d = S_DROP;
                                code_d  = 3'd3;
                            end
                        end else if (byte_data != SOH) begin
                            state_d = S_DROP;
                            code_d  = 3'd3;
                        end else if (val_q == {2'b00, exp_q}) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DROP;
                            code_d  = 3'd4;
                        end
                    end
                end
            end
            default: begin
                // DONE and DROP last one cycle, then the assembler starts clean.
                state_d = S_IDLE;
                buf_d   = '0;
                cnt_d   = '0;
                sum_d   = '0;
                snap_d  = '0;
                exp_d   = '0;
                tag_d   = '0;
                dig_d   = '0;
                val_d   = '0;
                tmo_d   = '0;
            end
        endcase

        if (store) begin
            buf_d[wr_lsb +: 8] = byte_data;
            cnt_d              = cnt_q + 1'b1;
            sum_d              = sum_q + byte_data;
        end

        // Publish on the same edge that accepts the final SOH so data and strobe line up.
        if (state_d == S_DONE) begin
            out_d = buf_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            snap_q  <= '0;
            exp_q   <= '0;
            tag_q   <= '0;
            dig_q   <= '0;
            val_q   <= '0;
            tmo_q   <= '0;
            code_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            snap_q  <= snap_d;
            exp_q   <= exp_d;
            tag_q   <= tag_d;
            dig_q   <= dig_d;
            val_q   <= val_d;
            tmo_q   <= tmo_d;
            code_q  <= code_d;
            rdy_q   <= !(state_d == S_DONE || state_d == S_DROP);
        end
    end

endmodule

// File: tb/tb_fix_rx_assembler.sv
// Purpose: self-checking bench for fix_rx_assembler: directed vector table, hand sequences and a random stream vs. a frame-level model.
// Latency: expects rx_enable on the cycle after the final SOH and a timeout drop exactly TIMEOUT_CYCLES idle cycles after the last byte.
// Backpressure: every byte is held until byte_ready is seen high, with a bounded wait.
module tb_fix_rx_assembler;

    localparam int MSG_LEN = 262;
    localparam int DW      = MSG_LEN * 8;
    localparam int TMO     = 16;

    typedef logic [7:0] bytes_t [$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          rx_enable;
    logic [DW-1:0] rx_fix_data;
    logic          frame_error;
    logic [2:0]    error_code;

    fix_rx_assembler #(
        .FIX_PAYLOAD_LEN(220),
        .FIX_HEADER_LEN (42),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .rx_enable  (rx_enable),
        .rx_fix_data(rx_fix_data),
        .frame_error(frame_error),
        .error_code (error_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Output monitor: records every strobe seen on the falling edge.
    int            n_rx = 0;
    int            n_fe = 0;
    time           rx_t = 0;
    time           fe_t = 0;
    bit            both_hi = 1'b0;
    int            ev_code[$];
    logic [DW-1:0] ev_data[$];
    always @(negedge clk) begin
        if (rx_enable) begin
            n_rx++;
            rx_t = $time;
            ev_code.push_back(0);
            ev_data.push_back(rx_fix_data);
        end
        if (frame_error) begin
            n_fe++;
            fe_t = $time;
            ev_code.push_back(int'(error_code));
            ev_data.push_back('0);
        end
        if (rx_enable && frame_error) both_hi = 1'b1;
    end

    time last_ret = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            for (int k = 0; k < MSG_LEN; k++) begin
                if (act[DW-1-8*k -: 8] !== exp[DW-1-8*k -: 8]) begin
                    $display("FAIL %s: byte %0d got %h expected %h", nm, k, act[DW-1-8*k -: 8], exp[DW-1-8*k -: 8]);
                    break;
                end
            end
        end
    endtask

    function automatic bytes_t str2q(input string s);
        bytes_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i] == "|" ? 8'h01 : 8'(s[i]));
        return q;
    endfunction

    function automatic bytes_t cat(input bytes_t a, input bytes_t b);
        bytes_t q = a;
        foreach (b[i]) q.push_back(b[i]);
        return q;
    endfunction

    function automatic logic [DW-1:0] pack(input bytes_t q, input int st, input int len);
        logic [DW-1:0] v = '0;
        for (int k = 0; k < len; k++) v[DW-1-8*k -: 8] = q[st+k];
        return v;
    endfunction

    function automatic int sum_mod(input bytes_t q, input int st, input int last);
        int s = 0;
        for (int k = st; k <= last; k++) s += int'(q[k]);
        return s % 256;
    endfunction

    function automatic bytes_t digits3(input int v);
        bytes_t q;
        q.push_back(8'(48 + (v / 100) % 10));
        q.push_back(8'(48 + (v / 10) % 10));
        q.push_back(8'(48 + v % 10));
        return q;
    endfunction

    // Called on a falling edge; returns on the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            n_checks++;
            n_err++;
            $display("FAIL send_byte: byte_ready got 0 expected 1 within 40 cycles");
        end
        @(negedge clk);
        byte_valid = 1'b0;
        last_ret   = $time;
    endtask

    task automatic send_q(input bytes_t q, input int gap);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (gap > 0) repeat (gap) @(negedge clk);
        end
    endtask

    // Frame-level reference model: scans a byte stream and lists the outcomes it must produce.
    int m_code[$];
    int m_start[$];
    int m_len[$];

    task automatic run_model(input bytes_t s);
        int     n, i, st, k, p, x, code, val;
        bit     found;
        bytes_t hdr;
        n   = s.size();
        i   = 0;
        hdr = str2q("8=FIX");
        while (i < n) begin
            if (s[i] != 8'h38) begin
                i++;
                continue;
            end
            st   = i;
            code = -1;
            for (k = 1; k <= 4; k++) begin
                if (st + k >= n) begin code = 5; break; end
                if (s[st+k] != hdr[k]) begin code = 2; break; end
            end
            if (code == 5) begin
                m_code.push_back(5); m_start.push_back(st); m_len.push_back(0);
                return;
            end
            if (code == 2) begin
                m_code.push_back(2); m_start.push_back(st); m_len.push_back(0);
                i = st + k + 1;
                continue;
            end
            p     = st + 5;
            found = 1'b0;
            while (!found && code < 0) begin
                if (p - st >= MSG_LEN) code = 1;
                else if (p >= n) code = 5;
                else if (p - 3 >= st + 5 && s[p-3] == 8'h01 && s[p-2] == 8'h31 && s[p-1] == 8'h30 && s[p] == 8'h3D) found = 1'b1;
                else p++;
            end
            val = 0;
            x   = p;
            if (found) begin
                for (x = p + 1; x <= p + 4; x++) begin
                    if (x - st >= MSG_LEN) begin code = 1; break; end
                    if (x >= n) begin code = 5; break; end
                    if (x <= p + 3) begin
                        if (s[x] < 8'h30 || s[x] > 8'h39) begin code = 3; break; end
                        val = val * 10 + int'(s[x]) - 48;
                    end else if (s[x] != 8'h01) begin
                        code = 3;
                        break;
                    end
                end
            end
            if (code == 5) begin
                m_code.push_back(5); m_start.push_back(st); m_len.push_back(0);
                return;
            end
            if (code == 1) begin
                m_code.push_back(1); m_start.push_back(st); m_len.push_back(0);
                i = st + MSG_LEN + 1;
            end else if (code == 3) begin
                m_code.push_back(3); m_start.push_back(st); m_len.push_back(0);
                i = x + 1;
            end else begin
                m_code.push_back(val == sum_mod(s, st, p - 3) ? 0 : 4);
                m_start.push_back(st);
                m_len.push_back(p + 5 - st);
                i = p + 5;
            end
        end
    endtask

    // Random segment: 0 good, 1 wrong checksum, 2 garbage, 3 bad begin, 4 bad digit, 5 checksum above 255.
    function automatic bytes_t gen_seg(input int kind);
        bytes_t q;
        string  cs = "ABCDEFGHIJ0123456789xyz";
        string  gs = "ab8=F|X1";
        int     v, s, idx;
        if (kind == 2) begin
            for (int i = 0; i < $urandom_range(1, 5); i++) q.push_back(8'(gs[$urandom_range(0, gs.len() - 1)]));
            return q;
        end
        q = str2q("8=FIX.4.2|");
        if (kind == 3) q[3] = 8'h59;
        for (int f = 0; f < $urandom_range(1, 4); f++) begin
            v = $urandom_range(11, 99);
            q.push_back(8'(48 + v / 10));
            q.push_back(8'(48 + v % 10));
            q.push_back(8'h3D);
            for (int c = 0; c < $urandom_range(1, 6); c++) q.push_back(8'(cs[$urandom_range(0, cs.len() - 1)]));
            q.push_back(8'h01);
        end
        s = sum_mod(q, 0, q.size() - 1);
        v = s;
        if (kind == 1) v = (s + $urandom_range(1, 255)) % 256;
        if (kind == 5) v = s + 256;
        q = cat(q, str2q("10="));
        q = cat(q, digits3(v));
        if (kind == 4) begin
            idx    = q.size() - $urandom_range(1, 3);
            q[idx] = 8'h78;
        end
        q.push_back(8'h01);
        return q;
    endfunction

    typedef struct {
        string txt;
        int    gap;
        int    exp_rx;
        int    exp_code;
    } vec_t;

    initial begin
        vec_t          tbl[12];
        bytes_t        q, maxq, stream;
        int            base_rx, base_fe, base_ev, st, t, nm;
        string         good;
        logic [DW-1:0] zero_w;

        good   = "8=FIX.4.2|9=5|35=0|10=161|";
        zero_w = '0;
        tbl[0]  = '{good, 0, 1, 0};
        tbl[1]  = '{"8=FIX.4.2|9=5|35=0|10=160|", 0, 0, 4};
        tbl[2]  = '{good, 0, 1, 0};
        tbl[3]  = '{{"xyz", good}, 0, 1, 0};
        tbl[4]  = '{"8=FIT.4.2|9=5|35=0|10=161|", 0, 0, 2};
        tbl[5]  = '{"8=FIX.4.2|9=5|35=0|10=1a1|", 0, 0, 3};
        tbl[6]  = '{good, 3, 1, 0};
        tbl[7]  = '{"8=FIX.4.2|9=5|35=0|10=16|", 0, 0, 3};
        tbl[8]  = '{"8=FIX.4.2|9=5|35=0|10=1611", 0, 0, 3};
        tbl[9]  = '{"8=FIX.4.2|9=5|35=0|10=417|", 0, 0, 4};
        tbl[10] = '{{"8", good}, 0, 0, 2};
        tbl[11] = '{good, 1, 1, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_ready", byte_ready, 0);
        chk("reset_rx_enable", rx_enable, 0);
        chk("reset_frame_error", frame_error, 0);
        chk("reset_error_code", error_code, 0);
        chk_data("reset_rx_fix_data", rx_fix_data, zero_w);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", byte_ready, 1);

        // Directed vector table.
        for (int v = 0; v < 12; v++) begin
            base_rx = n_rx;
            base_fe = n_fe;
            q = str2q(tbl[v].txt);
            send_q(q, tbl[v].gap);
            repeat (4) @(negedge clk);
            chk($sformatf("vec%0d_rx_count", v), n_rx - base_rx, tbl[v].exp_rx);
            chk($sformatf("vec%0d_err_count", v), n_fe - base_fe, 1 - tbl[v].exp_rx);
            if (tbl[v].exp_rx == 1) begin
                st = 0;
                while (q[st] != 8'h38) st++;
                chk_data($sformatf("vec%0d_data", v), rx_fix_data, pack(q, st, q.size() - st));
                chk($sformatf("vec%0d_latency", v), rx_t - last_ret, 0);
            end else begin
                chk($sformatf("vec%0d_code", v), error_code, tbl[v].exp_code);
            end
        end

        // Largest legal frame: exactly MSG_LEN bytes.
        maxq = str2q("8=FIX.4.2|58=");
        for (int k = 0; k < 241; k++) maxq.push_back(8'h41);
        maxq.push_back(8'h01);
        st = sum_mod(maxq, 0, maxq.size() - 1);
        maxq = cat(maxq, str2q("10="));
        maxq = cat(maxq, digits3(st));
        maxq.push_back(8'h01);
        base_rx = n_rx;
        base_fe = n_fe;
        send_q(maxq, 0);
        repeat (4) @(negedge clk);
        chk("max_len", maxq.size(), MSG_LEN);
        chk("max_rx_count", n_rx - base_rx, 1);
        chk("max_err_count", n_fe - base_fe, 0);
        chk_data("max_data", rx_fix_data, pack(maxq, 0, MSG_LEN));

        // Overflow: 263 bytes with no checksum tag.
        q = str2q("8=FIX");
        for (int k = 0; k < 258; k++) q.push_back(8'h41);
        base_fe = n_fe;
        for (int k = 0; k < 262; k++) send_byte(q[k]);
        @(negedge clk);
        chk("ovf_no_early_error", n_fe - base_fe, 0);
        send_byte(q[262]);
        chk("ovf_frame_error", frame_error, 1);
        chk("ovf_ready_low", byte_ready, 0);
        @(negedge clk);
        chk("ovf_ready_back", byte_ready, 1);
        chk("ovf_strobe_one_cycle", frame_error, 0);
        chk("ovf_code", error_code, 1);
        chk_data("ovf_data_held", rx_fix_data, pack(maxq, 0, MSG_LEN));

        // Timeout after a partial frame.
        base_fe = n_fe;
        send_q(str2q("8=FIX.4"), 0);
        t = 0;
        while (n_fe == base_fe && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_seen", n_fe - base_fe, 1);
        chk("tmo_code", error_code, 5);
        chk("tmo_cycles", (fe_t - last_ret) / 10, TMO);

        // Reset in the middle of a frame.
        send_q(str2q("8=FIX.4.2|9="), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rx_enable", rx_enable, 0);
        chk("rst_frame_error", frame_error, 0);
        chk("rst_error_code", error_code, 0);
        chk("rst_ready", byte_ready, 0);
        chk_data("rst_data", rx_fix_data, zero_w);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        base_rx = n_rx;
        base_fe = n_fe;
        q = str2q(good);
        send_q(q, 0);
        repeat (4) @(negedge clk);
        chk("post_rst_rx_count", n_rx - base_rx, 1);
        chk("post_rst_err_count", n_fe - base_fe, 0);
        chk_data("post_rst_data", rx_fix_data, pack(q, 0, q.size()));

        // Random stream with random gaps, checked against the frame-level model.
        base_ev = ev_code.size();
        for (int sgi = 0; sgi < 30; sgi++) stream = cat(stream, gen_seg(sgi == 29 ? 0 : int'($urandom_range(0, 5))));
        foreach (stream[i]) begin
            send_byte(stream[i]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        run_model(stream);
        chk("rand_event_count", ev_code.size() - base_ev, m_code.size());
        nm = m_code.size();
        if (ev_code.size() - base_ev < nm) nm = ev_code.size() - base_ev;
        for (int k = 0; k < nm; k++) begin
            chk($sformatf("rand_ev%0d_code", k), ev_code[base_ev + k], m_code[k]);
            if (m_code[k] == 0) chk_data($sformatf("rand_ev%0d_data", k), ev_data[base_ev + k], pack(stream, m_start[k], m_len[k]));
        end

        chk("strobes_exclusive", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
